// File: rtl/xentry_pkg.sv
// Shared xentry core types used by the L1 data cache controller.
// dcache_state_e names the cache sequencer states; memory_operation_e tags
// pipeline and L2 transfers as loads or stores.
package xentry_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WRITEBACK    = 2'd1,
        REFILL_SETUP = 2'd2,
        FILL         = 2'd3
    } dcache_state_e;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// Bundle of pipeline, datapath and L2 handshake signals around the L1 data
// cache controller. The master modport is the controller; the slave modport
// is the datapath/pipeline/L2 side. The perf counter outputs exist only when
// DCACHE_PERF_COUNTERS_EN is defined.
interface dcache_controller_if;
    import xentry_pkg::*;

    // pipeline request
    logic              pipe_req_valid;
    memory_operation_e pipe_req_type;
    logic              pipe_req_fulfilled;

    // datapath lookup and word counter status
    logic              hit;
    logic              clean_miss;
    logic              dirty_miss;
    logic              counter_done;

    // word-serial L2 handshake
    logic              l2_req_valid;
    memory_operation_e l2_req_type;
    logic              l2_req_fulfilled;

    // datapath controls
    logic              flush_mode;
    logic              load_mode;
    logic              clear_selected_dirty_bit;
    logic              clear_selected_valid_bit;
    logic              finish_new_line_install;
    logic              set_new_l2_block_address;
    logic              reset_counter;
    logic              decrement_counter;

`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0]       perf_hits;
    logic [31:0]       perf_misses;
    logic [31:0]       perf_writebacks;
`endif

    modport master (
        input  pipe_req_valid, pipe_req_type,
        input  hit, clean_miss, dirty_miss, counter_done,
        input  l2_req_fulfilled,
        output pipe_req_fulfilled,
        output l2_req_valid, l2_req_type,
        output flush_mode, load_mode, clear_selected_dirty_bit,
        output clear_selected_valid_bit, finish_new_line_install,
        output set_new_l2_block_address, reset_counter, decrement_counter
`ifdef DCACHE_PERF_COUNTERS_EN
        , output perf_hits, perf_misses, perf_writebacks
`endif
    );

    modport slave (
        output pipe_req_valid, pipe_req_type,
        output hit, clean_miss, dirty_miss, counter_done,
        output l2_req_fulfilled,
        input  pipe_req_fulfilled,
        input  l2_req_valid, l2_req_type,
        input  flush_mode, load_mode, clear_selected_dirty_bit,
        input  clear_selected_valid_bit, finish_new_line_install,
        input  set_new_l2_block_address, reset_counter, decrement_counter
`ifdef DCACHE_PERF_COUNTERS_EN
        , input perf_hits, perf_misses, perf_writebacks
`endif
    );

endinterface

// File: rtl/dcache_controller_perf_counters.sv
// dcache_perf_counters: hit / miss / writeback event counters for the L1 data
// cache controller. Each counter saturates at all-ones. Compiled only when
// DCACHE_PERF_COUNTERS_EN is defined.
`ifdef DCACHE_PERF_COUNTERS_EN
module dcache_perf_counters
    import xentry_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hit_evt_i,
    input  logic        miss_evt_i,
    input  logic        wb_evt_i,
    output logic [31:0] perf_hits_o,
    output logic [31:0] perf_misses_o,
    output logic [31:0] perf_writebacks_o
);

    logic [31:0] hits_q;
    logic [31:0] misses_q;
    logic [31:0] writebacks_q;

    // Count each event class independently, clearing on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q       <= 32'd0;
            misses_q     <= 32'd0;
            writebacks_q <= 32'd0;
        end else begin
            if (hit_evt_i) begin
                hits_q <= sat_inc32(hits_q);
            end
            if (miss_evt_i) begin
                misses_q <= sat_inc32(misses_q);
            end
            if (wb_evt_i) begin
                writebacks_q <= sat_inc32(writebacks_q);
            end
        end
    end

    assign perf_hits_o       = hits_q;
    assign perf_misses_o     = misses_q;
    assign perf_writebacks_o = writebacks_q;

endmodule
`endif

// File: rtl/dcache_controller.sv
// dcache_controller: sequencing FSM for the direct-mapped L1 data cache.
// Completes hits in IDLE, refills clean misses, and writes back dirty victims
// before refilling. Lines move word-serially over the L2 handshake in
// descending word order, paced by the datapath word counter.
// Optional feature macro: DCACHE_PERF_COUNTERS_EN adds saturating
// hit/miss/writeback counters (dcache_perf_counters).
module dcache_controller
    import xentry_pkg::*;
#(
    parameter int LINE_SIZE = 32,
    parameter int XLEN      = 32
) (
    input logic                 clk,
    input logic                 reset,
    dcache_controller_if.master bus
);

    localparam int WORDS_PER_LINE = LINE_SIZE / (XLEN / 8);

    localparam logic [1:0] S_IDLE         = IDLE;
    localparam logic [1:0] S_WRITEBACK    = WRITEBACK;
    localparam logic [1:0] S_REFILL_SETUP = REFILL_SETUP;
    localparam logic [1:0] S_FILL         = FILL;

    generate
        if (WORDS_PER_LINE < 1) begin : g_bad_geometry
            $error("dcache_controller: LINE_SIZE must hold at least one XLEN word");
        end
    endgenerate

    logic [1:0]        state_q;
    logic [1:0]        state_d;

    logic              pipe_req_fulfilled_s;
    logic              l2_req_valid_s;
    memory_operation_e l2_req_type_s;
    logic              flush_mode_s;
    logic              load_mode_s;
    logic              clear_dirty_s;
    logic              clear_valid_s;
    logic              finish_install_s;
    logic              set_block_addr_s;
    logic              reset_counter_s;
    logic              decrement_counter_s;

    // The request type only feeds optional bookkeeping; sink it here.
    logic              unused_req_type_s;
    assign unused_req_type_s = bus.pipe_req_type;

    // Hold the current sequencer state; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode for each sequencer state.
    always_comb begin
        state_d              = state_q;
        pipe_req_fulfilled_s = 1'b0;
        l2_req_valid_s       = 1'b0;
        l2_req_type_s        = LOAD;
        flush_mode_s         = 1'b0;
        load_mode_s          = 1'b0;
        clear_dirty_s        = 1'b0;
        clear_valid_s        = 1'b0;
        finish_install_s     = 1'b0;
        set_block_addr_s     = 1'b0;
        reset_counter_s      = 1'b0;
        decrement_counter_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.pipe_req_valid && bus.hit) begin
                    pipe_req_fulfilled_s = 1'b1;
                end else if (bus.pipe_req_valid && bus.clean_miss) begin
                    set_block_addr_s = 1'b1;
                    reset_counter_s  = 1'b1;
                    state_d          = S_FILL;
                end else if (bus.pipe_req_valid && bus.dirty_miss) begin
                    // Block address latches the victim tag for the writeback.
                    set_block_addr_s = 1'b1;
                    reset_counter_s  = 1'b1;
                    state_d          = S_WRITEBACK;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WRITEBACK: begin
                flush_mode_s   = 1'b1;
                l2_req_valid_s = 1'b1;
                l2_req_type_s  = STORE;
                if (bus.l2_req_fulfilled && !bus.counter_done) begin
                    decrement_counter_s = 1'b1;
                end else if (bus.l2_req_fulfilled) begin
                    // Victim fully written: invalidate so the refill sees a clean miss.
                    clear_dirty_s   = 1'b1;
                    clear_valid_s   = 1'b1;
                    reset_counter_s = 1'b1;
                    state_d         = S_REFILL_SETUP;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end

            S_REFILL_SETUP: begin
                // Line is invalid now, so the address latches the request tag.
                set_block_addr_s = 1'b1;
                state_d          = S_FILL;
            end

            S_FILL: begin
                load_mode_s    = 1'b1;
                l2_req_valid_s = 1'b1;
                l2_req_type_s  = LOAD;
                if (bus.l2_req_fulfilled && !bus.counter_done) begin
                    decrement_counter_s = 1'b1;
                end else if (bus.l2_req_fulfilled) begin
                    // Last word in; the held request hits in IDLE next cycle.
                    finish_install_s = 1'b1;
                    state_d          = S_IDLE;
                end else begin
                    state_d = S_FILL;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.pipe_req_fulfilled       = pipe_req_fulfilled_s;
    assign bus.l2_req_valid             = l2_req_valid_s;
    assign bus.l2_req_type              = l2_req_type_s;
    assign bus.flush_mode               = flush_mode_s;
    assign bus.load_mode                = load_mode_s;
    assign bus.clear_selected_dirty_bit = clear_dirty_s;
    assign bus.clear_selected_valid_bit = clear_valid_s;
    assign bus.finish_new_line_install  = finish_install_s;
    assign bus.set_new_l2_block_address = set_block_addr_s;
    assign bus.reset_counter            = reset_counter_s;
    assign bus.decrement_counter        = decrement_counter_s;

`ifdef DCACHE_PERF_COUNTERS_EN
    logic hit_evt_s;
    logic miss_evt_s;
    logic wb_evt_s;

    assign hit_evt_s  = pipe_req_fulfilled_s;
    assign miss_evt_s = (state_q == S_IDLE) && bus.pipe_req_valid && !bus.hit &&
                        (bus.clean_miss || bus.dirty_miss);
    assign wb_evt_s   = clear_dirty_s;

    dcache_perf_counters u_perf (
        .clk               (clk),
        .reset             (reset),
        .hit_evt_i         (hit_evt_s),
        .miss_evt_i        (miss_evt_s),
        .wb_evt_i          (wb_evt_s),
        .perf_hits_o       (bus.perf_hits),
        .perf_misses_o     (bus.perf_misses),
        .perf_writebacks_o (bus.perf_writebacks)
    );
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized scoreboard bench for dcache_controller. A simple line/counter
// datapath model reacts to the controller's strobes; for each request the
// expected sequence of observable control events is queued and a monitor
// compares every event the controller presents against that queue.
module tb_dcache_controller;
    import xentry_pkg::*;

    localparam int WPL = 8;

    // observed/expected vector bit positions
    // [10] l2_req_valid [9] l2_req_type [8] flush [7] load [6] clr_dirty
    // [5] clr_valid [4] finish [3] set_addr [2] reset_cnt [1] dec [0] fulfilled
    localparam logic [10:0] V_FULFILL = 11'b000_0000_0001;
    localparam logic [10:0] V_START   = 11'b000_0000_1100;
    localparam logic [10:0] V_REFILL  = 11'b000_0000_1000;

    logic clk;
    logic reset;
    dcache_controller_if bus();

    dcache_controller #(.LINE_SIZE(32), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q[$];

    // datapath model
    logic       line_valid = 1'b0;
    logic       line_dirty = 1'b0;
    logic [7:0] line_tag   = 8'd0;
    logic [7:0] req_tag    = 8'd0;
    int         dp_cnt     = 0;

    // perf tallies from request outcomes
    int exp_hits = 0;
    int exp_misses = 0;
    int exp_wb = 0;

    function automatic logic [10:0] obs();
        return {bus.l2_req_valid, logic'(bus.l2_req_type), bus.flush_mode, bus.load_mode,
                bus.clear_selected_dirty_bit, bus.clear_selected_valid_bit,
                bus.finish_new_line_install, bus.set_new_l2_block_address,
                bus.reset_counter, bus.decrement_counter, bus.pipe_req_fulfilled};
    endfunction

    // One L2 word handshake: store words flush, load words fill; the last
    // word of a writeback invalidates, the last word of a refill installs.
    function automatic logic [10:0] exp_word(input bit store, input bit last);
        logic [10:0] v;
        v = 11'd0;
        v[10] = 1'b1;
        v[9]  = store;
        if (store) v[8] = 1'b1; else v[7] = 1'b1;
        if (!last) v[1] = 1'b1;
        else if (store) begin v[6] = 1'b1; v[5] = 1'b1; v[2] = 1'b1; end
        else v[4] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every completion, address latch or L2 handshake
    // must match the next queued expectation.
    initial begin
        logic [10:0] ob;
        logic [10:0] e;
        forever begin
            @(negedge clk);
            ob = obs();
            if (!reset && (ob[0] || ob[3] || (bus.l2_req_valid && bus.l2_req_fulfilled))) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %b, expected no event", ob);
                end else begin
                    e = exp_q.pop_front();
                    if (ob !== e) begin
                        errors++;
                        $display("FAIL sb_event: got %b, expected %b", ob, e);
                    end
                end
            end
        end
    end

    task automatic drive_dp(input int mode, input int cyc);
        logic h;
        logic d;
        h = line_valid && (line_tag == req_tag);
        d = line_valid && line_dirty && !h;
        bus.hit          = h;
        bus.dirty_miss   = d;
        bus.clean_miss   = !h && !d;
        bus.counter_done = (dp_cnt == 0);
        case (mode)
            0:       bus.l2_req_fulfilled = 1'b1;
            1:       bus.l2_req_fulfilled = ((cyc % 3) == 2);
            default: bus.l2_req_fulfilled = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic step_dp();
        if (bus.reset_counter) dp_cnt = WPL - 1;
        else if (bus.decrement_counter) dp_cnt = dp_cnt - 1;
        if (bus.clear_selected_valid_bit) line_valid = 1'b0;
        if (bus.clear_selected_dirty_bit) line_dirty = 1'b0;
        if (bus.finish_new_line_install) begin
            line_valid = 1'b1;
            line_dirty = 1'b0;
            line_tag   = req_tag;
        end
    endtask

    task automatic check_perf(input int h, input int m, input int w);
`ifdef DCACHE_PERF_COUNTERS_EN
        chk("perf_hits", bus.perf_hits, 32'(h));
        chk("perf_misses", bus.perf_misses, 32'(m));
        chk("perf_writebacks", bus.perf_writebacks, 32'(w));
`else
        if (h < 0 || m < 0 || w < 0) $display("negative tally");
`endif
    endtask

    // scen: 0 hit, 1 clean miss, 2 dirty miss; abort_at>0 resets on that fill word.
    task automatic do_txn(input int scen, input int mode, input int abort_at);
        int  fills;
        bit  done;
        bit  aborted;
        int  cyc;
        req_tag = 8'($urandom);
        case (scen)
            0: begin line_valid = 1'b1; line_tag = req_tag; line_dirty = 1'($urandom); end
            1: begin line_valid = 1'($urandom); line_tag = req_tag ^ 8'h5A; line_dirty = 1'b0; end
            default: begin line_valid = 1'b1; line_dirty = 1'b1; line_tag = req_tag ^ 8'hA5; end
        endcase
        if (scen == 0) begin
            exp_q.push_back(V_FULFILL);
            exp_hits++;
        end else begin
            exp_misses++;
            exp_q.push_back(V_START);
            if (scen == 2) begin
                for (int w = WPL - 1; w >= 0; w--) exp_q.push_back(exp_word(1'b1, w == 0));
                exp_q.push_back(V_REFILL);
            end
            for (int w = WPL - 1; w >= 0; w--) exp_q.push_back(exp_word(1'b0, w == 0));
            exp_q.push_back(V_FULFILL);
        end
        bus.pipe_req_valid = 1'b1;
        bus.pipe_req_type  = memory_operation_e'($urandom_range(0, 1));
        fills = 0;
        done = 1'b0;
        aborted = 1'b0;
        cyc = 0;
        while (cyc < 400 && !done && !aborted) begin
            drive_dp(mode, cyc);
            @(negedge clk);
            if (bus.pipe_req_fulfilled) done = 1'b1;
            if (bus.l2_req_valid && bus.l2_req_fulfilled && bus.load_mode) fills++;
            step_dp();
            if (abort_at != 0 && fills == abort_at) begin
                reset = 1'b1;
                aborted = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.pipe_req_valid   = 1'b0;
        bus.l2_req_fulfilled = 1'b0;
        if (aborted) begin
            reset = 1'b0;
            exp_q.delete();
            exp_hits = 0; exp_misses = 0; exp_wb = 0;
            line_valid = 1'b0;
            dp_cnt = 0;
            @(negedge clk);
            chk("abort_l2_req_valid", 32'(bus.l2_req_valid), 32'd0);
            chk("abort_load_mode", 32'(bus.load_mode), 32'd0);
            chk("abort_outputs", 32'(obs()), 32'd0);
            check_perf(0, 0, 0);
            @(posedge clk);
            #1;
        end else if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: got no completion in %0d cycles, expected completion", cyc);
            exp_q.delete();
        end else begin
            if (scen != 0) exp_hits++;
            if (scen == 2) exp_wb++;
        end
    endtask

    // IDLE with no request: stray L2 fulfils and lookup flags must do nothing.
    task automatic idle_cycles(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 3));
            bus.hit              = (r == 0);
            bus.clean_miss       = (r == 1);
            bus.dirty_miss       = (r == 2);
            bus.counter_done     = 1'($urandom);
            bus.l2_req_fulfilled = 1'($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("idle_quiet", 32'(obs()), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.l2_req_fulfilled = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_hits = 0; exp_misses = 0; exp_wb = 0;
        dp_cnt = 0;
    endtask

    initial begin
        reset                = 1'b1;
        bus.pipe_req_valid   = 1'b0;
        bus.pipe_req_type    = LOAD;
        bus.hit              = 1'b0;
        bus.clean_miss       = 1'b0;
        bus.dirty_miss       = 1'b0;
        bus.counter_done     = 1'b0;
        bus.l2_req_fulfilled = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(obs()), 32'd0);
        check_perf(0, 0, 0);
        @(posedge clk);
        #1;

        do_txn(0, 0, 0);      // hit, zero latency
        do_txn(1, 0, 0);      // clean miss, back-to-back L2
        do_txn(2, 1, 0);      // dirty miss, L2 every third cycle
        idle_cycles(5);
        do_txn(1, 0, 4);      // reset on the 4th fill handshake
        do_txn(0, 2, 0);      // hit right after abort
        idle_cycles(4);

        reset_pulse();
        do_txn(0, 0, 0);
        do_txn(0, 2, 0);
        do_txn(0, 1, 0);
        do_txn(1, 2, 0);
        do_txn(2, 2, 0);
        check_perf(5, 2, 1);

        for (int t = 0; t < 40; t++) begin
            do_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
            idle_cycles(int'($urandom_range(0, 2)));
        end
        check_perf(exp_hits, exp_misses, exp_wb);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
